// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields plus an immediate into instruction words, queues them in a
// small in-order FIFO and tags each emitted word with its instruction-memory byte address.
module instr_encoder #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [31:0]          out_addr,
    output logic                 err_valid,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [31:0]          mem_q [DEPTH];
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]          addr_q, addr_d;
    logic                 err_valid_q, err_valid_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [31:0] enc_word;
    logic [1:0]  enc_code;
    logic        fmt_err, mis_err, rng_err;
    logic        accept, push, pop, reject;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Range checks: the bits above the encodable field must be a pure sign extension.
    always_comb begin
        enc_word = '0;
        fmt_err  = 1'b0;
        mis_err  = 1'b0;
        rng_err  = 1'b0;
        case (in_fmt)
            FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                rng_err  = (|in_imm[31:11]) & ~(&in_imm[31:11]);
            end
            FMT_S: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                rng_err  = (|in_imm[31:11]) & ~(&in_imm[31:11]);
            end
            FMT_B: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                rng_err  = (|in_imm[31:12]) & ~(&in_imm[31:12]);
                mis_err  = in_imm[0];
            end
            FMT_U: begin
                enc_word = {in_imm[31:12], in_rd, in_opcode};
                rng_err  = |in_imm[11:0];
            end
            FMT_J: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                rng_err  = (|in_imm[31:20]) & ~(&in_imm[31:20]);
                mis_err  = in_imm[0];
            end
            default: fmt_err = 1'b1;
        endcase
        enc_code = fmt_err ? 2'd3 : (mis_err ? 2'd2 : (rng_err ? 2'd1 : 2'd0));
    end

    // in_ready depends only on registered occupancy and flush, never on out_ready.
    assign in_ready  = (count_q < CNT_W'(DEPTH)) & ~flush;
    assign out_valid = (count_q != '0);
    assign accept    = in_valid & in_ready;
    assign reject    = accept & (enc_code != 2'd0);
    assign push      = accept & (enc_code == 2'd0);
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        addr_d      = addr_q;
        err_valid_d = reject;
        err_code_d  = reject ? enc_code : err_code_q;
        err_cnt_d   = (reject && !(&err_cnt_q)) ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            addr_d   = BASE_ADDR;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                addr_d   = addr_q + 32'd4;
            end
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            addr_q      <= BASE_ADDR;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
            err_cnt_q   <= '0;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            addr_q      <= addr_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Storage carries no reset; the occupancy count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= enc_word;
    end

    assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign out_addr  = addr_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_cnt   = err_cnt_q;
endmodule
